valu_wb_round: RTL and testbench
================================

Name: valu_wb_round

Overview:
- Result-side consumer of the vector add/min/max ALU pipeline.
- Takes each ALU output beat (data, address, byte enables, mask flag, fixed-point vd/vd1 bits) and applies vxrm rounding to averaging-op results.
- Buffers beats in a FIFO and drains them to the VRF write port with a valid/ready handshake.
- Counts written beats per instruction and pulses done; asserts almost-full so the issue stage throttles (the ALU pipeline cannot stall).

Parameters:
- DATA_WIDTH, 64, beat width in bits
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ADDR_WIDTH, 32, VRF address width
- FIFO_DEPTH, 16, beat buffer entries (power of 2)
- AFULL_MARGIN, 8, free-entry threshold for fifo_afull; must be ≥ ALU pipeline depth + 1
- CNT_WIDTH, 16, beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; latches cfg_* for a new instruction
- cfg_beats  in  CNT_WIDTH  number of write beats expected
- cfg_sew  in  2  element width (0=8, 1=16, 2=32, 3=64)
- cfg_vxrm  in  2  rounding mode (0=rnu, 1=rne, 2=rdn, 3=rod)
- in_valid  in  1  ALU beat valid
- in_vec  in  DATA_WIDTH  ALU result
- in_addr  in  ADDR_WIDTH  destination address
- in_be  in  BE_WIDTH  byte enables
- in_mask  in  1  mask-producing op result
- in_fxp  in  1  averaging op; rounding applies
- in_vd  in  BE_WIDTH  per-element result LSB, at element's lowest byte index
- in_vd1  in  BE_WIDTH  per-element shifted-out bit, same placement
- wr_valid  out  1  VRF write request
- wr_ready  in  1  VRF accepts
- wr_data  out  DATA_WIDTH  write data
- wr_addr  out  ADDR_WIDTH  write address
- wr_be  out  BE_WIDTH  write byte enables
- wr_mask  out  1  mask-register write
- fifo_afull  out  1  free entries ≤ AFULL_MARGIN
- busy  out  1  state RUN
- done  out  1  one-cycle pulse when the instruction's last beat is written
- ovf_err  out  1  sticky: beat dropped on full FIFO
- stray_err  out  1  sticky: beat received in IDLE

Behaviour:
Reset (rst low, async):
- FIFO empty; state IDLE; counter 0; config registers 0.
- All outputs 0: wr_valid, wr_data, wr_addr, wr_be, wr_mask, busy, done, ovf_err, stray_err, fifo_afull.

Round stage (1 registered cycle):
- Element k at SEW has r_k from in_vd/in_vd1 bit at byte index k<<cfg_sew:
  - rnu: r = vd1
  - rne: r = vd1 & vd
  - rdn: r = 0
  - rod: r = vd1 & ~vd, and the result LSB is forced to 1 when vd1 is set (add r gives the same result).
- Element result = (elem + r) mod 2^SEW; no carry crosses element boundaries.
- Applied only when in_fxp=1 and in_mask=0; otherwise data passes unchanged.
- be, addr and mask pass through unchanged.

FIFO:
- Push on registered round-stage valid.
- Pop on wr_valid & wr_ready.
- When full, a push is accepted only if a pop happens the same cycle; otherwise the beat is dropped and ovf_err sets.
- wr_* is driven from the FIFO head (registered read); wr_valid = not empty.
- wr_data/addr/be/mask are held stable while wr_valid & ~wr_ready.
- Minimum latency from in_valid to wr_valid is 2 cycles.
- fifo_afull is registered from the next-cycle occupancy.

FSM:
- IDLE:
  - cfg_start loads the counter with cfg_beats and latches sew/vxrm.
  - Goes to RUN; if cfg_beats=0, pulses done next cycle and stays IDLE.
- RUN:
  - Each pop decrements the counter.
  - The pop taking the counter 1→0 pulses done the next cycle and returns to IDLE.
  - cfg_start in RUN is ignored.
- Beats arriving in IDLE are still buffered and written, but set stray_err; pops in IDLE do not count.
- Error flags clear only on reset or on an accepted cfg_start.
- Reset mid-instruction: FIFO contents discarded, no done pulse.

Decomposition:
- Shared package holds:
  - SEW encodings
  - vxrm encodings (VXRM_RNU/RNE/RDN/ROD)
  - FSM state typedef (IDLE, RUN)
- Natural sub-module: wb_sync_fifo (parameterised width/depth, async active-low reset, count output). The round stage and FSM stay in the top.

Test Plan:
- SEW8 rnu, in_vec byte0=0x40, in_vd1[0]=1, in_fxp=1 → wr_data byte0=0x41, other bytes unchanged, wr_valid 2 cycles after in_valid.
- SEW8 byte0=0x41, vd=1, vd1=1 → rne 0x42; rod 0x41; rdn 0x41. Repeat at SEW16 lane 1 (be bit 2) → same rounding on bits 31:16.
- SEW8 byte0=0xFF, vd1=1, rnu → byte0=0x00, byte1 unchanged (no cross-element carry). in_mask=1 with vd1 set → data unchanged.
- cfg_beats=3, wr_ready low for 5 cycles after the first beat → wr_* held stable, 3 beats written in order, done pulses once after the 3rd pop, busy falls.
- 17 back-to-back beats with wr_ready=0 at depth 16 → fifo_afull by occupancy 8, beat 17 dropped, ovf_err=1; a later cfg_start clears it.
- Assert rst low mid-RUN with 4 beats queued → all outputs 0 immediately, no done; a following cfg_beats=0 start → done pulse in 1 cycle.

Source files
------------

// File: rtl/valu_wb_round_pkg.sv
// Shared encodings and helpers for the vector ALU write-back rounding block.
package valu_wb_round_pkg;

    // Element width selector
    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    // Fixed-point rounding modes
    typedef enum logic [1:0] {
        VXRM_RNU = 2'd0,
        VXRM_RNE = 2'd1,
        VXRM_RDN = 2'd2,
        VXRM_ROD = 2'd3
    } vxrm_e;

    // Instruction tracking state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Rounding increment for one element. For rod, adding vd1 & ~vd is the
    // same as forcing the LSB to one whenever a set bit was shifted out.
    function automatic logic round_inc(input vxrm_e mode, input logic vd, input logic vd1);
        logic r;
        r = 1'b0;
        case (mode)
            VXRM_RNU: r = vd1;
            VXRM_RNE: r = vd1 & vd;
            VXRM_RDN: r = 1'b0;
            VXRM_ROD: r = vd1 & ~vd;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/valu_wb_round_fifo.sv
// Synchronous FIFO with a registered head output. The head register always
// holds the oldest entry while the FIFO is non-empty, so the consumer sees
// valid data the cycle after the first push and the data stays put until popped.
module wb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_after_pop;
    logic [CW-1:0]    w_count_next;
    logic             w_load;
    logic             w_bypass;

    assign w_rd_ptr_next = r_rd_ptr + AW'(i_pop);
    assign w_after_pop   = r_count - CW'(i_pop);
    assign w_count_next  = w_after_pop + CW'(i_push);
    // Head register reloads when the head moves, or when the FIFO goes non-empty.
    assign w_load        = (w_count_next != '0) && (i_pop || (r_count == '0));
    // The entry written this cycle becomes the head when nothing older remains.
    assign w_bypass      = i_push && (w_after_pop == '0);

    // Storage array write port
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Registered head read with write-through for the empty case
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_load) begin
            r_dout <= w_bypass ? i_din : r_mem[w_rd_ptr_next];
        end
    end

    assign o_dout  = r_dout;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/valu_wb_round.sv
// Write-back stage for the vector add/min/max ALU: rounds averaging results,
// buffers beats and drains them to the VRF write port, tracking completion.
module valu_wb_round
    import valu_wb_round_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [CNT_WIDTH-1:0]  cfg_beats,
    input  logic [1:0]            cfg_sew,
    input  logic [1:0]            cfg_vxrm,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic                  in_mask,
    input  logic                  in_fxp,
    input  logic [BE_WIDTH-1:0]   in_vd,
    input  logic [BE_WIDTH-1:0]   in_vd1,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BE_WIDTH-1:0]   wr_be,
    output logic                  wr_mask,
    output logic                  fifo_afull,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err,
    output logic                  stray_err
);

    localparam int ENTRY_W = 1 + BE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    // Latched instruction configuration
    sew_e                  r_sew;
    vxrm_e                 r_vxrm;

    // Round stage registers
    logic                  r_rnd_valid;
    logic [DATA_WIDTH-1:0] r_rnd_data;
    logic [ADDR_WIDTH-1:0] r_rnd_addr;
    logic [BE_WIDTH-1:0]   r_rnd_be;
    logic                  r_rnd_mask;

    // Control state
    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_done;
    logic                  r_afull;
    logic                  r_ovf;
    logic                  r_stray;

    logic [DATA_WIDTH-1:0] w_res8;
    logic [DATA_WIDTH-1:0] w_res16;
    logic [DATA_WIDTH-1:0] w_res32;
    logic [DATA_WIDTH-1:0] w_res64;
    logic [DATA_WIDTH-1:0] w_rounded;

    logic [ENTRY_W-1:0]    w_head;
    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_fifo_count;
    logic [CW-1:0]         w_count_next;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_start_acc;
    logic                  w_last_pop;
    logic                  w_busy;
    logic                  w_done_next;

    // Per-element rounded results for each element width; each element adds
    // its own increment inside its slice so carries never cross lanes.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_e8
            logic w_r;
            assign w_r = round_inc(r_vxrm, in_vd[gi], in_vd1[gi]);
            assign w_res8[gi*8 +: 8] = in_vec[gi*8 +: 8] + {7'd0, w_r};
        end
        for (gi = 0; gi < DATA_WIDTH / 16; gi++) begin : g_e16
            logic w_r;
            assign w_r = round_inc(r_vxrm, in_vd[gi*2], in_vd1[gi*2]);
            assign w_res16[gi*16 +: 16] = in_vec[gi*16 +: 16] + {15'd0, w_r};
        end
        for (gi = 0; gi < DATA_WIDTH / 32; gi++) begin : g_e32
            logic w_r;
            assign w_r = round_inc(r_vxrm, in_vd[gi*4], in_vd1[gi*4]);
            assign w_res32[gi*32 +: 32] = in_vec[gi*32 +: 32] + {31'd0, w_r};
        end
        for (gi = 0; gi < DATA_WIDTH / 64; gi++) begin : g_e64
            logic w_r;
            assign w_r = round_inc(r_vxrm, in_vd[gi*8], in_vd1[gi*8]);
            assign w_res64[gi*64 +: 64] = in_vec[gi*64 +: 64] + {63'd0, w_r};
        end
    endgenerate

    // Select the rounded result for the active element width; non-averaging
    // and mask-producing beats pass through untouched.
    always_comb begin
        w_rounded = in_vec;
        if (in_fxp && !in_mask) begin
            case (r_sew)
                SEW_8:   w_rounded = w_res8;
                SEW_16:  w_rounded = w_res16;
                SEW_32:  w_rounded = w_res32;
                SEW_64:  w_rounded = w_res64;
                default: w_rounded = in_vec;
            endcase
        end
    end

    // Round stage pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= '0;
            r_rnd_addr  <= '0;
            r_rnd_be    <= '0;
            r_rnd_mask  <= 1'b0;
        end else begin
            r_rnd_valid <= in_valid;
            if (in_valid) begin
                r_rnd_data <= w_rounded;
                r_rnd_addr <= in_addr;
                r_rnd_be   <= in_be;
                r_rnd_mask <= in_mask;
            end
        end
    end

    // A full FIFO still takes a beat if the head leaves the same cycle.
    assign w_pop        = ~w_empty & wr_ready;
    assign w_push       = r_rnd_valid & (~w_full | w_pop);
    assign w_drop       = r_rnd_valid & w_full & ~w_pop;
    assign w_count_next = w_fifo_count + CW'(w_push) - CW'(w_pop);

    wb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_din   ({r_rnd_mask, r_rnd_be, r_rnd_addr, r_rnd_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_fifo_count)
    );

    assign wr_valid = ~w_empty;
    assign {wr_mask, wr_be, wr_addr, wr_data} = w_head;

    // Almost-full tracks the occupancy the FIFO will have after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_count_next >= CW'(FIFO_DEPTH - AFULL_MARGIN));
        end
    end

    assign w_start_acc = cfg_start & (r_state == IDLE);
    assign w_last_pop  = (r_state == RUN) & w_pop & (r_cnt == CNT_WIDTH'(1));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (cfg_start && (cfg_beats != '0)) w_state_next = RUN;
            RUN:  if (w_last_pop) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: busy level and the done pulse request
    always_comb begin
        w_busy      = (r_state == RUN);
        w_done_next = (w_start_acc & (cfg_beats == '0)) | w_last_pop;
    end

    // Beat counter and latched configuration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_sew  <= SEW_8;
            r_vxrm <= VXRM_RNU;
        end else if (w_start_acc) begin
            r_cnt  <= cfg_beats;
            r_sew  <= sew_e'(cfg_sew);
            r_vxrm <= vxrm_e'(cfg_vxrm);
        end else if ((r_state == RUN) && w_pop) begin
            r_cnt  <= r_cnt - CNT_WIDTH'(1);
        end
    end

    // Done pulse and sticky error flags; an accepted start clears the errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_stray <= 1'b0;
        end else begin
            r_done  <= w_done_next;
            r_ovf   <= (w_start_acc ? 1'b0 : r_ovf) | w_drop;
            r_stray <= (w_start_acc ? 1'b0 : r_stray) | (in_valid & (r_state == IDLE));
        end
    end

    assign fifo_afull = r_afull;
    assign busy       = w_busy;
    assign done       = r_done;
    assign ovf_err    = r_ovf;
    assign stray_err  = r_stray;

endmodule

// File: tb/tb_valu_wb_round.sv
// Directed and randomized checks of the write-back rounding block against a
// behavioural model of the rounding rules and an expected-write queue.
module tb_valu_wb_round;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_beats = '0;
    logic [1:0]  cfg_sew = '0;
    logic [1:0]  cfg_vxrm = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_vec = '0;
    logic [31:0] in_addr = '0;
    logic [7:0]  in_be = '0;
    logic        in_mask = 1'b0;
    logic        in_fxp = 1'b0;
    logic [7:0]  in_vd = '0;
    logic [7:0]  in_vd1 = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [63:0] wr_data;
    logic [31:0] wr_addr;
    logic [7:0]  wr_be;
    logic        wr_mask;
    logic        fifo_afull;
    logic        busy;
    logic        done;
    logic        ovf_err;
    logic        stray_err;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int m_sew = 0;
    int m_vxrm = 0;
    bit rand_ready = 1'b0;
    logic [104:0] exp_q[$];
    logic [104:0] mon_e;

    valu_wb_round dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_beats(cfg_beats), .cfg_sew(cfg_sew), .cfg_vxrm(cfg_vxrm),
        .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr), .in_be(in_be),
        .in_mask(in_mask), .in_fxp(in_fxp), .in_vd(in_vd), .in_vd1(in_vd1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_mask(wr_mask), .fifo_afull(fifo_afull), .busy(busy),
        .done(done), .ovf_err(ovf_err), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Element LSBs sit at the lowest byte of each element, so vd is bit 0 of every byte.
    function automatic logic [7:0] vd_of(input logic [63:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[8*i];
        return r;
    endfunction

    // Rounding rules stated directly: rnu adds the shifted-out bit, rne rounds
    // an exact half toward even, rdn truncates, rod jams the LSB to one.
    function automatic logic [63:0] model_round(input logic [63:0] v, input logic [7:0] vd1,
                                                input int sew, input int vxrm,
                                                input logic fxp, input logic msk);
        logic [63:0] res;
        longint unsigned eb, m, e;
        int bi;
        if (!fxp || msk) return v;
        eb = 64'd8 << sew;
        m = (eb == 64) ? '1 : ((64'd1 << eb) - 1);
        res = '0;
        for (int k = 0; k < 64 / int'(eb); k++) begin
            e = (v >> (k * eb)) & m;
            bi = k * int'(eb / 8);
            case (vxrm)
                0: e = e + 64'(vd1[bi]);
                1: if (vd1[bi] && ((e & 1) == 1)) e = e + 1;
                3: if (vd1[bi]) e = e | 1;
                default: ;
            endcase
            res = res | ((e & m) << (k * eb));
        end
        return res;
    endfunction

    task automatic start(input int beats, input int sew, input int vxrm);
        cfg_start = 1'b1;
        cfg_beats = 16'(beats);
        cfg_sew = 2'(sew);
        cfg_vxrm = 2'(vxrm);
        m_sew = sew;
        m_vxrm = vxrm;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [63:0] vec, input logic [31:0] addr, input logic [7:0] be,
                        input logic msk, input logic fxp, input logic [7:0] vd1, input bit keep);
        in_valid = 1'b1;
        in_vec = vec;
        in_addr = addr;
        in_be = be;
        in_mask = msk;
        in_fxp = fxp;
        in_vd = vd_of(vec);
        in_vd1 = vd1;
        if (keep) exp_q.push_back({msk, be, addr, model_round(vec, vd1, m_sew, m_vxrm, fxp, msk)});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int d0);
        int n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({tag, "_drain_in_time"}, 128'(n < 400), 128'(1));
        chk({tag, "_done_once"}, 128'(done_cnt - d0), 128'(1));
        chk({tag, "_busy_low"}, 128'(busy), 128'(0));
    endtask

    task automatic dir_round(input string tag, input int sew, input int vxrm,
                             input logic [63:0] vec, input logic [7:0] vd1,
                             input logic msk, input logic fxp, input logic [63:0] expd);
        int d0 = done_cnt;
        start(1, sew, vxrm);
        send(vec, 32'h0000_0100, 8'hFF, msk, fxp, vd1, 1'b1);
        chk({tag, "_valid_at_1"}, 128'(wr_valid), 128'(0));
        tick();
        chk({tag, "_valid_at_2"}, 128'(wr_valid), 128'(1));
        chk({tag, "_data"}, 128'(wr_data), 128'(expd));
        wait_idle(tag, d0);
    endtask

    // Randomized VRF back-pressure when enabled
    always @(negedge clk) begin
        if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
    end

    // Write-port scoreboard and done-pulse counter, sampled mid low phase
    always @(negedge clk) begin
        #3;
        if (rst === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
                chk("wr_expected_beat", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_beat", 128'({wr_mask, wr_be, wr_addr, wr_data}), 128'(mon_e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [63:0] v;
        logic [63:0] held;
        int nb;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", 128'({wr_valid, wr_mask, wr_be, wr_addr, wr_data, fifo_afull,
                                   busy, done, ovf_err, stray_err}), 128'(0));
        rst = 1'b1;
        tick();
        chk("idle_outputs", 128'({wr_valid, busy, done, ovf_err, stray_err, fifo_afull}), 128'(0));
        wr_ready = 1'b1;

        // Directed rounding cases
        dir_round("sew8_rnu",  0, 0, 64'h0123_4567_89AB_CD40, 8'h01, 1'b0, 1'b1, 64'h0123_4567_89AB_CD41);
        dir_round("sew8_rne",  0, 1, 64'h0123_4567_89AB_CD41, 8'h01, 1'b0, 1'b1, 64'h0123_4567_89AB_CD42);
        dir_round("sew8_rod",  0, 3, 64'h0123_4567_89AB_CD41, 8'h01, 1'b0, 1'b1, 64'h0123_4567_89AB_CD41);
        dir_round("sew8_rdn",  0, 2, 64'h0123_4567_89AB_CD41, 8'h01, 1'b0, 1'b1, 64'h0123_4567_89AB_CD41);
        dir_round("sew16_rne", 1, 1, 64'h0123_4567_0041_CD40, 8'h04, 1'b0, 1'b1, 64'h0123_4567_0042_CD40);
        dir_round("sew16_rod", 1, 3, 64'h0123_4567_0041_CD40, 8'h04, 1'b0, 1'b1, 64'h0123_4567_0041_CD40);
        dir_round("sew16_rdn", 1, 2, 64'h0123_4567_0041_CD40, 8'h04, 1'b0, 1'b1, 64'h0123_4567_0041_CD40);
        dir_round("sew8_wrap", 0, 0, 64'h0123_4567_89AB_CDFF, 8'h01, 1'b0, 1'b1, 64'h0123_4567_89AB_CD00);
        dir_round("mask_pass", 0, 0, 64'h0123_4567_89AB_CD40, 8'h01, 1'b1, 1'b1, 64'h0123_4567_89AB_CD40);
        dir_round("nofxp_pass", 0, 0, 64'h0123_4567_89AB_CD40, 8'h01, 1'b0, 1'b0, 64'h0123_4567_89AB_CD40);
        dir_round("sew64_rnu", 3, 0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h01, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-pressure: head must hold while the VRF stalls
        d0 = done_cnt;
        wr_ready = 1'b0;
        start(3, 0, 0);
        send(64'h1111_2222_3333_4444, 32'h10, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b1);
        send(64'h5555_6666_7777_8888, 32'h11, 8'hF0, 1'b1, 1'b1, 8'hAA, 1'b1);
        send(64'h9999_AAAA_BBBB_CCCC, 32'h12, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1);
        held = exp_q[0][63:0];
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 128'(wr_valid), 128'(1));
            chk("stall_hold", 128'({wr_addr, wr_data}), 128'({32'h10, held}));
            tick();
        end
        chk("stall_busy", 128'(busy), 128'(1));
        wr_ready = 1'b1;
        wait_idle("stall", d0);

        // Overflow: 17 back-to-back beats into a 16-deep FIFO
        d0 = done_cnt;
        wr_ready = 1'b0;
        start(16, 2, 1);
        for (int i = 0; i < 17; i++) begin
            v = {$urandom, $urandom};
            send(v, 32'(i), 8'hFF, 1'b0, 1'b1, 8'($urandom), i < 16);
            chk("ovf_afull", 128'(fifo_afull), 128'((16 - i) <= 8));
            chk("ovf_not_yet", 128'(ovf_err), 128'(0));
        end
        tick();
        chk("ovf_set", 128'(ovf_err), 128'(1));
        chk("ovf_full_afull", 128'(fifo_afull), 128'(1));
        wr_ready = 1'b1;
        wait_idle("ovf", d0);
        chk("ovf_sticky", 128'(ovf_err), 128'(1));
        start(0, 0, 0);
        chk("zero_start_done", 128'(done), 128'(1));
        chk("ovf_cleared", 128'(ovf_err), 128'(0));
        tick();
        chk("zero_start_done_pulse", 128'(done), 128'(0));

        // Stray beat while idle is still written but flagged
        send(64'hDEAD_BEEF_0000_0001, 32'h77, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("stray_set", 128'(stray_err), 128'(1));
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("stray_drained", 128'(exp_q.size()), 128'(0));
        start(0, 0, 0);
        chk("stray_cleared", 128'(stray_err), 128'(0));
        tick();

        // Reset in the middle of an instruction with beats queued
        wr_ready = 1'b0;
        start(10, 1, 0);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 32'(i), 8'hFF, 1'b0, 1'b1, 8'($urandom), 1'b1);
        tick();
        tick();
        chk("pre_reset_valid", 128'(wr_valid), 128'(1));
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", 128'({wr_valid, wr_mask, wr_be, wr_addr, wr_data, fifo_afull,
                                         busy, done, ovf_err, stray_err}), 128'(0));
        exp_q.delete();
        m_sew = 0;
        m_vxrm = 0;
        tick();
        tick();
        rst = 1'b1;
        wr_ready = 1'b1;
        tick();
        tick();
        chk("reset_no_done", 128'(done_cnt - d0), 128'(0));
        start(0, 0, 0);
        chk("after_reset_zero_done", 128'(done), 128'(1));
        tick();

        // Randomized instructions against the model
        rand_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            d0 = done_cnt;
            nb = $urandom_range(1, 12);
            start(nb, $urandom_range(0, 3), $urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                send({$urandom, $urandom}, $urandom, 8'($urandom), ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            end
            wait_idle("rand", d0);
            chk("rand_no_ovf", 128'(ovf_err), 128'(0));
        end
        rand_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
